// File: rtl/reg_write_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arb
// Purpose  : Round-robin arbiter giving N_REQ requesters write access to one
//            shared register through an IDLE -> ARB -> WRITE sequence.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   busy,
  output logic [7:0]             wr_cnt
);

  localparam int                 IW       = $clog2(N_REQ);
  localparam logic [IW-1:0]      LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0]   ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;
  logic [7:0]       wr_cnt_q;

  logic [IW-1:0]    win_d;
  logic [IW-1:0]    hi_idx_d;
  logic             hi_found_d;
  logic [IW-1:0]    lo_idx_d;
  logic [IW-1:0]    ptr_d;
  logic [WIDTH-1:0] wsel_d;
  logic             req_win_d;

  // Descending scan leaves the lowest set index at or above ptr in hi_idx,
  // and the lowest set index overall in lo_idx as the wrap-around fallback.
  always_comb begin
    hi_idx_d   = '0;
    hi_found_d = 1'b0;
    lo_idx_d   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx_d = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_idx_d   = IW'(i);
          hi_found_d = 1'b1;
        end
      end
    end
    win_d = hi_found_d ? hi_idx_d : lo_idx_d;
  end

  always_comb begin
    wsel_d    = '0;
    req_win_d = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == IW'(i)) begin
        wsel_d    = wdata[i*WIDTH +: WIDTH];
        req_win_d = req[i];
      end
    end
    ptr_d = (win_q == LAST_IDX) ? '0 : win_q + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      q_q      <= '0;
      busy_q   <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= ARB;
            busy_q  <= 1'b1;
          end
        end
        ARB: begin
          if (|req) begin
            win_q   <= win_d;
            state_q <= WRITE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        WRITE: begin
          // A requester that dropped its request before the write is skipped.
          if (req_win_d) begin
            q_q   <= wsel_d;
            gnt_q <= ONE_HOT0 << win_q;
            ptr_q <= ptr_d;
            if (wr_cnt_q != 8'hFF) begin
              wr_cnt_q <= wr_cnt_q + 8'd1;
            end
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign q      = q_q;
  assign busy   = busy_q;
  assign wr_cnt = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arb.sv
`default_nettype none
// tb_reg_write_arb : directed and random stimulus compared every cycle against
// a transaction-level model of the shared-register arbiter.
module tb_reg_write_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [7:0]     wr_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: phase counts cycles since a request was accepted.
  int           m_phase;
  int           m_ptr;
  int           m_win;
  int           m_cnt;
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  logic         m_busy;

  int           gq_idx[$];
  int           gq_cyc[$];
  logic [W-1:0] gq_q[$];

  reg_write_arb #(.N_REQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .busy   (busy),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_cnt   = 0;
    m_q     = '0;
    m_gnt   = '0;
    m_busy  = 1'b0;
  endfunction

  function automatic void m_step();
    m_gnt = '0;
    if (m_phase == 0) begin
      if (req != '0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (req == '0) begin
        m_phase = 0;
      end else begin
        bit f;
        f = 1'b0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!f && ((req >> j) & N'(1)) != '0) begin
            f     = 1'b1;
            m_win = j;
          end
        end
        m_phase = 2;
      end
    end else begin
      if (((req >> m_win) & N'(1)) != '0) begin
        m_q   = W'(wdata >> (m_win * W));
        m_gnt = N'(1) << m_win;
        m_ptr = (m_win + 1) % N;
        if (m_cnt < 255) m_cnt++;
      end
      m_phase = 0;
    end
    m_busy = (m_phase != 0);
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("gnt", gnt, m_gnt);
      chk("q", q, m_q);
      chk("busy", busy, m_busy);
      chk("wr_cnt", wr_cnt, m_cnt);
      chk("gnt_onehot", $countones(gnt) <= 1, 1);
      if (gnt != '0) begin
        gq_idx.push_back($clog2(gnt));
        gq_cyc.push_back(cyc);
        gq_q.push_back(q);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_seen", ok, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int start;
    int exp_idx[5];
    logic [W-1:0] last;

    exp_idx = '{0, 1, 2, 3, 0};

    // Reset values
    step();
    step();
    chk("rst_q", q, 8'h00);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    rst = 1'b0;

    // Single requester and latency
    wdata[2*W +: W] = 8'h3C;
    req = 4'b0100;
    t0 = cyc;
    wait_gnt(10);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_q", q, 8'h3C);
    chk("single_wr_cnt", wr_cnt, 1);
    chk("single_latency", cyc - t0, 3);
    req = 4'b0000;

    // Pointer at 3: requester 3 first, then wrap to 0, then pointer at 1
    step();
    step();
    wdata[3*W +: W] = 8'h77;
    wdata[0*W +: W] = 8'h66;
    req = 4'b1001;
    wait_gnt(10);
    chk("wrap_gnt3", gnt, 4'b1000);
    chk("wrap_q3", q, 8'h77);
    req = 4'b0001;
    wait_gnt(10);
    chk("wrap_gnt0", gnt, 4'b0001);
    chk("wrap_q0", q, 8'h66);
    req = 4'b1111;
    wait_gnt(10);
    chk("wrap_ptr1", gnt, 4'b0010);
    req = 4'b0000;
    step();
    step();

    // Reset asserted in WRITE cancels the write
    wdata[0*W +: W] = 8'hA5;
    req = 4'b0001;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstw_q", q, 8'h00);
    chk("rstw_gnt", gnt, 4'b0000);
    chk("rstw_wr_cnt", wr_cnt, 0);
    chk("rstw_busy", busy, 0);
    req = 4'b0000;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstw_no_gnt", gnt, 4'b0000);
    end

    // Round-robin with all requesters held
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(8'h10 + i);
    start = gq_idx.size();
    req = 4'b1111;
    for (int i = 0; i < 40 && gq_idx.size() < start + 5; i++) step();
    req = 4'b0000;
    chk("rr_count", gq_idx.size() >= start + 5, 1);
    if (gq_idx.size() >= start + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_order", gq_idx[start+i], exp_idx[i]);
        chk("rr_q", gq_q[start+i], W'(8'h10 + exp_idx[i]));
        if (i > 0) chk("rr_spacing", gq_cyc[start+i] - gq_cyc[start+i-1], 3);
      end
    end

    // Abort: requester 1 drops its request before WRITE
    step();
    step();
    step();
    req = 4'b0010;
    step();
    step();
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_gnt", gnt, 4'b0000);
    end
    chk("abort_q", q, 8'h10);
    chk("abort_wr_cnt", wr_cnt, 5);
    chk("abort_busy", busy, 0);

    // Saturation of the write counter
    do_reset();
    last = '0;
    for (int n = 0; n < 260; n++) begin
      last = W'($urandom);
      wdata[0*W +: W] = last;
      req = 4'b0001;
      wait_gnt(10);
    end
    req = 4'b0000;
    step();
    step();
    chk("sat_wr_cnt", wr_cnt, 255);
    chk("sat_q", q, last);

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 99) < 40) req = N'($urandom);
      if ($urandom_range(0, 99) < 50) wdata = (N*W)'({$urandom, $urandom});
      step();
    end
    rst = 1'b0;
    req = '0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_write_arb.md
REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the register write port (2..8).
REQ-002 Parameter WIDTH, default 8, width of the shared data register in bits.
REQ-003 Port clk, input, 1, clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port req, input, N_REQ, per-requester write request; bit i belongs to requester i.
REQ-006 Port wdata, input, N_REQ*WIDTH, write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 Port gnt, output, N_REQ, one-hot write acknowledge, registered.
REQ-008 Port q, output, WIDTH, shared register contents, registered.
REQ-009 Port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 Port wr_cnt, output, 8, count of completed writes, saturating at 255.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ARB, WRITE.
REQ-012 IDLE: if req != 0, go to ARB; otherwise stay in IDLE.
REQ-013 ARB: latch a winner index win by round-robin from pointer ptr: the lowest i >= ptr with req[i]=1, else the lowest i < ptr with req[i]=1; go to WRITE.
REQ-014 ARB entered with req == 0 (requests dropped after IDLE sampled them): no winner latched; return to IDLE.
REQ-015 WRITE with req[win]=1: q takes wdata slice win; gnt[win] = 1 for exactly this cycle; ptr = (win+1) mod N_REQ; wr_cnt += 1 unless already 255; go to IDLE.
REQ-016 WRITE with req[win]=0 (abort): q, ptr and wr_cnt unchanged; gnt stays 0; go to IDLE.
REQ-017 gnt SHALL be all-zero in every cycle except a non-aborted WRITE cycle, and never have more than one bit set.
REQ-018 wdata SHALL be sampled only in the WRITE cycle; requesters hold req and wdata stable until gnt is seen.
REQ-019 Latency: req rising in IDLE at edge n gives busy=1 after edge n, ARB at n+1, q/gnt updated at edge n+2; minimum spacing between grants is 3 cycles.
REQ-020 A requester still asserting req after its gnt SHALL be treated as a new request; round-robin guarantees every continuously requesting requester is granted within N_REQ grants.
REQ-021 ptr SHALL wrap from N_REQ-1 to 0.
REQ-022 busy SHALL be derived from the registered state only (no combinational path from req).

Reset
REQ-023 rst high SHALL immediately force state=IDLE, q=0, gnt=0, busy=0, ptr=0, wr_cnt=0, win=0, regardless of clk.
REQ-024 Reset asserted in ARB or WRITE SHALL cancel the operation: no partial write and no gnt pulse after release.
REQ-025 The first rising clk edge with rst low SHALL evaluate IDLE transitions normally.

Verification
REQ-026 Reset: drive rst=1 mid-WRITE with req=4'b0001, wdata0=8'hA5 -> q=8'h00, gnt=0, wr_cnt=0 immediately; no gnt after release.
REQ-027 Single requester: req=4'b0100, wdata2=8'h3C held -> gnt=4'b0100 for one cycle, 2 edges after IDLE sampling; q=8'h3C; wr_cnt=1; ptr=3.
REQ-028 Round-robin: req=4'b1111 held, wdata i = 8'h10+i -> grant order 0,1,2,3,0; q sequence 10,11,12,13,10; grants 3 cycles apart.
REQ-029 Pointer wrap: ptr=3, req=4'b1001 -> requester 3 granted, then requester 0; ptr returns to 0 then 1.
REQ-030 Abort: req=4'b0010 asserted for 2 cycles only so req[1]=0 in WRITE -> gnt stays 0, q unchanged, wr_cnt unchanged, FSM back in IDLE.
REQ-031 Saturation: 260 back-to-back single-requester writes -> wr_cnt holds at 255, q tracks the last written data.
